// File: rtl/selen_ifetch_pkg.sv
// Shared types for the instruction-fetch responder: FSM states, fetch-buffer
// entry layout and the word returned for unmapped fetch addresses.
package selen_ifetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W      = ADDR_W_DEF - 2;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OORR  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_W_DEF-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/selen_ifetch_if.sv
// Core instruction-fetch port: the core drives request/address, the
// responder returns a same-cycle ack with the instruction word.
interface selen_ifetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              i_req_val;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ack;
  logic [DATA_W-1:0] i_ack_rdata;

  modport master (output i_req_val, output i_req_addr,
                  input  i_req_ack, input  i_ack_rdata);
  modport slave  (input  i_req_val, input  i_req_addr,
                  output i_req_ack, output i_ack_rdata);
endinterface

// File: rtl/selen_ifetch_buf.sv
// One tagged fetch-buffer entry: valid bit with reset/clear, tag and data
// storage written on load, and a combinational tag compare.
module selen_ifetch_buf
  import selen_ifetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [TAG_W-1:0]      load_tag,
  input  logic [DATA_W_DEF-1:0] load_data,
  input  logic [TAG_W-1:0]      look_tag,
  output logic                  match,
  output buf_entry_t            entry
);

  logic                  valid_q;
  logic [TAG_W-1:0]      tag_q;
  logic [DATA_W_DEF-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid_q <= 1'b0;
    else if (clr)  valid_q <= 1'b0;
    else if (load) valid_q <= 1'b1;
  end

  // Payload is only observable through a valid hit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load && !clr) begin
      tag_q  <= load_tag;
      data_q <= load_data;
    end
  end

  assign match = valid_q && (tag_q == look_tag);
  assign entry = '{valid: valid_q, tag: tag_q, data: data_q};

endmodule

// File: rtl/selen_ifetch_responder.sv
// Memory-side responder for core instruction fetches with a tagged fetch buffer.
// Optional next-word prefetch entry enabled by SELEN_IFETCH_PREFETCH_EN.
module selen_ifetch_responder
  import selen_ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_AW = 16,
  parameter int MEM_LAT = 2,
  parameter logic [DATA_W-1:0] OOR_DATA = RV32_NOP
) (
  input  logic              clk,
  input  logic              rst,
  selen_ifetch_if.slave     fetch,
  input  logic              flush,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_ready
);

  localparam int TW = ADDR_W - 2;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  function automatic logic is_oor(input logic [TW-1:0] t);
    return |(t >> MEM_AW);
  endfunction

  fetch_state_t     state_q, state_d;
  logic [TW-1:0]    cap_tag_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             discard_q, disc_d;

  logic [TW-1:0]     req_tag;
  logic              hit, hit_any;
  logic              pri_match, pri_load;
  logic [TW-1:0]     pri_ld_tag;
  logic [DATA_W-1:0] pri_ld_data, hit_data;
  buf_entry_t        pri_entry;
  logic              unused_bits;

  assign req_tag = fetch.i_req_addr[ADDR_W-1:2];

  selen_ifetch_buf u_pri (
    .clk(clk), .rst(rst), .clr(flush), .load(pri_load),
    .load_tag(pri_ld_tag), .load_data(pri_ld_data), .look_tag(req_tag),
    .match(pri_match), .entry(pri_entry)
  );

`ifdef SELEN_IFETCH_PREFETCH_EN
  logic          pf_q, pf_d, nxt_match, nxt_load, pf_ok;
  logic [TW:0]   pf_sum;
  logic [TW-1:0] pf_tag;
  buf_entry_t    nxt_entry;

  selen_ifetch_buf u_nxt (
    .clk(clk), .rst(rst), .clr(flush), .load(nxt_load),
    .load_tag(cap_tag_q), .load_data(mem_rdata), .look_tag(req_tag),
    .match(nxt_match), .entry(nxt_entry)
  );

  assign pf_sum   = {1'b0, req_tag} + (TW + 1)'(1);
  assign pf_tag   = pf_sum[TW-1:0];
  assign pf_ok    = !pf_sum[TW] && !is_oor(pf_tag)
                    && !(nxt_entry.valid && nxt_entry.tag == pf_tag);
  assign hit_any  = pri_match || nxt_match;
  assign hit_data = pri_match ? pri_entry.data : nxt_entry.data;
`else
  assign hit_any  = pri_match;
  assign hit_data = pri_entry.data;
`endif

  assign hit               = fetch.i_req_val && !flush && hit_any;
  assign fetch.i_req_ack   = hit;
  assign fetch.i_ack_rdata = hit ? hit_data : '0;
  assign mem_req           = (state_q == ISSUE);
  assign mem_addr          = (state_q == ISSUE) ? cap_tag_q[MEM_AW-1:0] : '0;
  assign unused_bits       = ^{fetch.i_req_addr[1:0], pri_entry.valid, pri_entry.tag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      resp_ready <= 1'b0;
`ifdef SELEN_IFETCH_PREFETCH_EN
      pf_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= disc_d;
      resp_ready <= 1'b1;
`ifdef SELEN_IFETCH_PREFETCH_EN
      pf_q       <= pf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    cap_tag_q <= cap_d;
  end

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_tag_q;
    cnt_d       = cnt_q;
    disc_d      = discard_q;
    pri_load    = 1'b0;
    pri_ld_tag  = cap_tag_q;
    pri_ld_data = mem_rdata;
`ifdef SELEN_IFETCH_PREFETCH_EN
    pf_d        = pf_q;
    nxt_load    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        disc_d = 1'b0;
        if (fetch.i_req_val && !hit) begin
          cap_d   = req_tag;
          state_d = is_oor(req_tag) ? OORR : ISSUE;
`ifdef SELEN_IFETCH_PREFETCH_EN
          pf_d    = 1'b0;
        end else if (hit) begin
          // A NEXT hit becomes the primary entry; then look one word further.
          if (!pri_match) begin
            pri_load    = 1'b1;
            pri_ld_tag  = nxt_entry.tag;
            pri_ld_data = nxt_entry.data;
          end
          if (pf_ok) begin
            cap_d   = pf_tag;
            pf_d    = 1'b1;
            state_d = ISSUE;
          end
`endif
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
        if (flush) disc_d = 1'b1;
      end
      WAIT: begin
        if (flush) disc_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
`ifdef SELEN_IFETCH_PREFETCH_EN
          if (pf_q) nxt_load = !discard_q && !flush;
          else      pri_load = !discard_q && !flush;
`else
          pri_load = !discard_q && !flush;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OORR: begin
        pri_load    = !flush;
        pri_ld_data = OOR_DATA;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
